// File: rtl/tpx3_link_status_pkg.sv
// Shared lane-state encodings, counter widths and helpers for the Timepix3 link-status monitor.
package tpx3_link_status_pkg;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_UP   = 2'd1,
        ST_LOST = 2'd2
    } lane_state_t;

    localparam int FAST_MS = 32;
    localparam int CNT_W   = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/tpx3_lane_monitor.sv
// One link flag: 2-flop synchroniser, debounce filter, DOWN/UP/LOST state machine,
// hold timer for visible loss events and a saturating loss counter.
module tpx3_lane_monitor
    import tpx3_link_status_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int HOLD_MS  = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             async_in,
    input  logic             tick,
    input  logic             fast,
    input  logic             clr_cnt,
    output logic             filt,
    output logic             up_nxt,
    output logic             lost_nxt,
    output logic             led,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLD_MS + 1);

    logic              sync_p0;
    logic              sync_p1;
    logic [DB_W-1:0]   db_cnt;
    lane_state_t       state;
    lane_state_t       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              loss_evt;

    // stage p0/p1: metastability guard for the asynchronous flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
        end
    end

    // debounce: the run of differing samples must reach DEBOUNCE before the filtered value flips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (sync_p1 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            filt   <= sync_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        loss_evt  = 1'b0;
        case (state)
            ST_DOWN: begin
                if (filt) state_nxt = ST_UP;
            end
            ST_UP: begin
                if (!filt) begin
                    state_nxt = ST_LOST;
                    hold_nxt  = HOLD_W'(HOLD_MS);
                    loss_evt  = 1'b1;
                end
            end
            ST_LOST: begin
                if (filt) begin
                    state_nxt = ST_UP;
                end else if (tick) begin
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_nxt = ST_DOWN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_DOWN;
                hold_nxt  = '0;
            end
        endcase
    end

    assign up_nxt   = (state_nxt == ST_UP);
    assign lost_nxt = (state_nxt == ST_LOST);

    // LED and counter are registered from the next state so they move together with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_DOWN;
            hold_cnt <= '0;
            led      <= 1'b0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            led      <= up_nxt | (lost_nxt & fast);
            if (clr_cnt)
                loss_cnt <= '0;
            else if (loss_evt)
                loss_cnt <= sat_inc(loss_cnt);
        end
    end

endmodule

// File: rtl/tpx3_link_status.sv
// Board link-status monitor: per-lane RX_READY and ETH_STATUS_OK monitors, ms prescaler,
// heartbeat and fast-blink generators, and the registered LED / LINKUP summary.
module tpx3_link_status
    import tpx3_link_status_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int TICK_DIV  = 125000,
    parameter int DEBOUNCE  = 4,
    parameter int HOLD_MS   = 250,
    parameter int BLINK_MS  = 500
) (
    input  logic                       BUS_CLK,
    input  logic                       BUS_RST,
    input  logic [NUM_LANES-1:0]       RX_READY,
    input  logic                       ETH_STATUS_OK,
    input  logic                       CLR_CNT,
    output logic [NUM_LANES-1:0]       LED,
    output logic [3:0]                 FMC_LED,
    output logic                       LINKUP,
    output logic [CNT_W*NUM_LANES-1:0] LOSS_CNT
);

    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int FAST_W  = $clog2(FAST_MS);

    logic [PRE_W-1:0]     presc;
    logic                 tick;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [FAST_W-1:0]    fast_cnt;
    logic                 hb;
    logic                 fast;
    logic                 up_any;
    logic                 lost_any;
    logic [NUM_LANES-1:0] lane_up_nxt;
    logic [NUM_LANES-1:0] lane_lost_nxt;
    logic [NUM_LANES-1:0] lane_unused_filt;
    logic                 eth_filt;
    logic                 eth_unused_up;
    logic                 eth_unused_lost;
    logic                 eth_unused_led;
    logic [CNT_W-1:0]     eth_unused_cnt;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PRE_W'(TICK_DIV - 1)) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + PRE_W'(1);
            tick  <= 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            blink_cnt <= '0;
            fast_cnt  <= '0;
            hb        <= 1'b0;
            fast      <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
                blink_cnt <= '0;
                hb        <= ~hb;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            if (fast_cnt == FAST_W'(FAST_MS - 1)) begin
                fast_cnt <= '0;
                fast     <= ~fast;
            end else begin
                fast_cnt <= fast_cnt + FAST_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tpx3_lane_monitor #(
            .DEBOUNCE (DEBOUNCE),
            .HOLD_MS  (HOLD_MS)
        ) u_lane (
            .clk      (BUS_CLK),
            .rst      (BUS_RST),
            .async_in (RX_READY[i]),
            .tick     (tick),
            .fast     (fast),
            .clr_cnt  (CLR_CNT),
            .filt     (lane_unused_filt[i]),
            .up_nxt   (lane_up_nxt[i]),
            .lost_nxt (lane_lost_nxt[i]),
            .led      (LED[i]),
            .loss_cnt (LOSS_CNT[CNT_W*i +: CNT_W])
        );
    end

    // only the debounced flag of the Ethernet monitor is consumed
    tpx3_lane_monitor #(
        .DEBOUNCE (DEBOUNCE),
        .HOLD_MS  (HOLD_MS)
    ) u_eth (
        .clk      (BUS_CLK),
        .rst      (BUS_RST),
        .async_in (ETH_STATUS_OK),
        .tick     (tick),
        .fast     (fast),
        .clr_cnt  (1'b0),
        .filt     (eth_filt),
        .up_nxt   (eth_unused_up),
        .lost_nxt (eth_unused_lost),
        .led      (eth_unused_led),
        .loss_cnt (eth_unused_cnt)
    );

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            LINKUP   <= 1'b0;
            up_any   <= 1'b0;
            lost_any <= 1'b0;
        end else begin
            LINKUP   <= eth_filt;
            up_any   <= |lane_up_nxt;
            lost_any <= |lane_lost_nxt;
        end
    end

    assign FMC_LED = {LINKUP, up_any, hb, lost_any};

endmodule

// File: tb/tb_tpx3_link_status.sv
// Scoreboard bench for tpx3_link_status: stimulus queues timed expectations, a negedge monitor checks them.
module tb_tpx3_link_status;

    localparam int NL = 8;

    logic          BUS_CLK       = 1'b0;
    logic          BUS_RST       = 1'b1;
    logic [NL-1:0] RX_READY      = '0;
    logic          ETH_STATUS_OK = 1'b0;
    logic          CLR_CNT       = 1'b0;
    logic [NL-1:0]   LED;
    logic [3:0]      FMC_LED;
    logic            LINKUP;
    logic [8*NL-1:0] LOSS_CNT;

    typedef struct {
        string       name;
        int          due;
        int          sel;
        logic [63:0] mask;
        logic [63:0] val;
    } chk_t;

    chk_t sb[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   r_cyc   = 0;

    tpx3_link_status #(
        .NUM_LANES (NL),
        .TICK_DIV  (4),
        .DEBOUNCE  (4),
        .HOLD_MS   (8),
        .BLINK_MS  (4)
    ) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST       (BUS_RST),
        .RX_READY      (RX_READY),
        .ETH_STATUS_OK (ETH_STATUS_OK),
        .CLR_CNT       (CLR_CNT),
        .LED           (LED),
        .FMC_LED       (FMC_LED),
        .LINKUP        (LINKUP),
        .LOSS_CNT      (LOSS_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;
    always @(posedge BUS_CLK) cyc <= cyc + 1;

    function automatic logic [63:0] field(input int sel);
        case (sel)
            0:       return {56'd0, LED};
            1:       return {60'd0, FMC_LED};
            2:       return {63'd0, LINKUP};
            default: return LOSS_CNT;
        endcase
    endfunction

    // fast toggles after every 32nd tick; first tick 4 cycles after reset release
    function automatic logic fast_at(input int c);
        int k;
        if (c - r_cyc - 1 < 0) return 1'b0;
        k = (c - r_cyc - 1) / 128;
        return (k % 2) == 1;
    endfunction

    always @(negedge BUS_CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [63:0] act;
                act = field(sb[i].sel) & sb[i].mask;
                n_total++;
                if (act == sb[i].val)
                    n_pass++;
                else
                    $display("FAIL %s @cycle %0d: got %h, want %h", sb[i].name, cyc, act, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic expect_at(input string nm, input int dly, input int sel,
                             input logic [63:0] mask, input logic [63:0] val);
        chk_t c;
        c.name = nm;
        c.due  = cyc + dly;
        c.sel  = sel;
        c.mask = mask;
        c.val  = val;
        sb.push_back(c);
    endtask

    initial begin
        int d;

        step(3);
        n_total++;
        if (LED == 8'h00) n_pass++;
        else $display("FAIL rst_led_now: got %h", LED);
        n_total++;
        if (FMC_LED == 4'h0) n_pass++;
        else $display("FAIL rst_fmc_now: got %h", FMC_LED);
        n_total++;
        if (LINKUP == 1'b0) n_pass++;
        else $display("FAIL rst_linkup_now: got %b", LINKUP);
        n_total++;
        if (LOSS_CNT == 64'h0) n_pass++;
        else $display("FAIL rst_loss_now: got %h", LOSS_CNT);
        expect_at("rst_led", 0, 0, 64'hFF, 64'h0);
        expect_at("rst_fmc", 0, 1, 64'hF, 64'h0);
        expect_at("rst_linkup", 0, 2, 64'h1, 64'h0);
        expect_at("rst_loss", 0, 3, '1, 64'h0);
        step(1);

        BUS_RST = 1'b0;
        r_cyc = cyc;
        expect_at("hb_pre_first", 16, 1, 64'hF, 64'h0);
        expect_at("hb_first", 17, 1, 64'hF, 64'h2);
        expect_at("hb_pre_second", 32, 1, 64'hF, 64'h2);
        expect_at("hb_second", 33, 1, 64'hF, 64'h0);
        expect_at("idle_led", 100, 0, 64'hFF, 64'h0);
        expect_at("idle_loss", 100, 3, '1, 64'h0);
        step(105);

        RX_READY = 8'h05;
        ETH_STATUS_OK = 1'b1;
        expect_at("up_led_early", 6, 0, 64'hFF, 64'h00);
        expect_at("up_led", 7, 0, 64'hFF, 64'h05);
        expect_at("up_fmc2", 7, 1, 64'h4, 64'h4);
        expect_at("linkup_early", 6, 2, 64'h1, 64'h0);
        expect_at("linkup", 7, 2, 64'h1, 64'h1);
        expect_at("fmc3_linkup", 7, 1, 64'h8, 64'h8);
        step(20);

        RX_READY = 8'h04;
        expect_at("glitch_led", 15, 0, 64'hFF, 64'h05);
        expect_at("glitch_loss0", 15, 3, 64'hFF, 64'h0);
        expect_at("glitch_fmc0", 15, 1, 64'h1, 64'h0);
        step(3);
        RX_READY = 8'h05;
        step(20);

        while ((cyc - r_cyc) % 4 != 2) step(1);
        RX_READY = 8'h01;
        expect_at("drop_loss2_early", 6, 3, 64'hFF_0000, 64'h0);
        expect_at("drop_loss2", 7, 3, 64'hFF_0000, 64'h01_0000);
        expect_at("drop_fmc0_early", 6, 1, 64'h1, 64'h0);
        expect_at("drop_fmc0_entry", 7, 1, 64'h1, 64'h1);
        expect_at("drop_led2_fast", 20, 0, 64'h4, {61'd0, fast_at(cyc + 19), 2'b00});
        expect_at("drop_fmc0_last", 38, 1, 64'h1, 64'h1);
        expect_at("drop_fmc0_expired", 39, 1, 64'h1, 64'h0);
        expect_at("drop_led_down", 39, 0, 64'hFF, 64'h01);
        expect_at("drop_fmc2_lane0", 39, 1, 64'h4, 64'h4);
        step(50);

        RX_READY = 8'h05;
        step(15);
        CLR_CNT = 1'b1;
        step(1);
        CLR_CNT = 1'b0;
        expect_at("clr_loss", 0, 3, '1, 64'h0);
        step(5);

        RX_READY = 8'h01;
        expect_at("recov_loss2", 7, 3, 64'hFF_0000, 64'h01_0000);
        expect_at("recov_fmc0_lost", 16, 1, 64'h1, 64'h1);
        expect_at("recov_fmc0_up", 17, 1, 64'h1, 64'h0);
        expect_at("recov_led2", 17, 0, 64'h4, 64'h4);
        expect_at("recov_loss2_final", 30, 3, 64'hFF_0000, 64'h01_0000);
        step(10);
        RX_READY = 8'h05;
        step(30);

        for (int k = 0; k < 300; k++) begin
            RX_READY = 8'h04;
            step(10);
            RX_READY = 8'h05;
            step(10);
            if (k == 99) expect_at("toggle_cnt100", 0, 3, 64'hFF, 64'd100);
        end
        expect_at("toggle_sat", 0, 3, 64'hFF, 64'd255);
        expect_at("toggle_led", 0, 0, 64'hFF, 64'h05);
        step(1);

        RX_READY = 8'h04;
        expect_at("clrwin_before", 6, 3, 64'hFF, 64'd255);
        expect_at("clrwin_result", 7, 3, 64'hFF, 64'd0);
        expect_at("clrwin_hold", 10, 3, 64'hFF, 64'd0);
        expect_at("clrwin_lost", 7, 1, 64'h1, 64'h1);
        step(6);
        CLR_CNT = 1'b1;
        step(1);
        CLR_CNT = 1'b0;
        step(5);

        BUS_RST = 1'b1;
        expect_at("midrst_led", 0, 0, 64'hFF, 64'h0);
        expect_at("midrst_fmc", 0, 1, 64'hF, 64'h0);
        expect_at("midrst_linkup", 0, 2, 64'h1, 64'h0);
        expect_at("midrst_loss", 0, 3, '1, 64'h0);
        expect_at("midrst_hold_led", 2, 0, 64'hFF, 64'h0);
        step(3);
        BUS_RST = 1'b0;
        expect_at("post_led_early", 6, 0, 64'hFF, 64'h00);
        expect_at("post_led", 7, 0, 64'hFF, 64'h04);
        expect_at("post_linkup", 7, 2, 64'h1, 64'h1);
        expect_at("post_loss", 50, 3, '1, 64'h0);
        expect_at("post_fmc0", 50, 1, 64'h1, 64'h0);
        step(60);

        d = sb.size();
        for (int i = 0; i < d; i++) begin
            n_total++;
            $display("FAIL %s: never reached, due cycle %0d, now %0d", sb[i].name, sb[i].due, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
